// File: rtl/uart_tx_cfg_if.sv
// Request side of the configurable UART transmitter: payload, per-frame config and the valid/ready pair.
// Handshake: a frame is accepted on the rising clock edge where i_valid && o_ready; payload/config are sampled on that edge only.
interface uart_tx_cfg_if #(
    parameter int DBIT_MAX = 8,
    parameter int NB_LEN   = 4
);
    logic                i_valid;
    logic [DBIT_MAX-1:0] i_data;
    logic [NB_LEN-1:0]   i_cfg_len;
    logic [1:0]          i_cfg_parity;
    logic                i_cfg_stop2;
    logic                o_ready;

    modport master (
        output i_valid, i_data, i_cfg_len, i_cfg_parity, i_cfg_stop2,
        input  o_ready
    );

    modport slave (
        input  i_valid, i_data, i_cfg_len, i_cfg_parity, i_cfg_stop2,
        output o_ready
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (1..DBIT_MAX data bits, none/even/odd parity, 1 or 2 stop bits).
// Optional line-break generation is compiled in when UART_TX_BREAK_EN is defined.
module uart_tx_cfg #(
    parameter int DBIT_MAX = 8,
    parameter int SB_TICK  = 16,
    parameter int NB_LEN   = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_s_tick,
`ifdef UART_TX_BREAK_EN
    input  logic        i_break,
`endif
    uart_tx_cfg_if.slave bus_if,
    output logic        o_busy,
    output logic        o_tx_done_tick,
    output logic        o_tx,
    output logic [2:0]  dbg_state_o
);

    localparam int CNT_W = (SB_TICK > 2) ? $clog2(SB_TICK) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
`ifdef UART_TX_BREAK_EN
        , S_BREAK,
        S_BREAK_MARK
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    tick_q, tick_d;
    logic [NB_LEN-1:0]   bit_q, bit_d;
    logic [NB_LEN-1:0]   len_q, len_d;
    logic [DBIT_MAX-1:0] shift_q, shift_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                stop2_q, stop2_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;

    logic [NB_LEN-1:0]   len_eff;
    logic [DBIT_MAX-1:0] data_masked;
    logic                bit_end;
    logic                accept;
    logic                break_req;

    // Out-of-range lengths fall back to the full width; bits above len are zeroed so parity ignores them.
    always_comb begin
        len_eff = bus_if.i_cfg_len;
        if (bus_if.i_cfg_len == '0 || bus_if.i_cfg_len > NB_LEN'(DBIT_MAX))
            len_eff = NB_LEN'(DBIT_MAX);
        data_masked = '0;
        for (int i = 0; i < DBIT_MAX; i++) begin
            if (NB_LEN'(i) < len_eff)
                data_masked[i] = bus_if.i_data[i];
        end
    end

`ifdef UART_TX_BREAK_EN
    assign break_req = i_break;
`else
    assign break_req = 1'b0;
`endif

    // A pending break masks ready so the handshake never reports an accept that is not taken.
    assign bus_if.o_ready = (state_q == S_IDLE) && !break_req;
    assign accept         = bus_if.i_valid && bus_if.o_ready;
    assign bit_end        = i_s_tick && (tick_q == CNT_W'(SB_TICK - 1));

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        len_d     = len_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        done_d    = 1'b0;

        if (i_s_tick)
            tick_d = bit_end ? '0 : tick_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                tick_d = '0;
                bit_d  = '0;
                if (break_req) begin
`ifdef UART_TX_BREAK_EN
                    state_d = S_BREAK;
                    tx_d    = 1'b0;
`endif
                end else if (accept) begin
                    state_d   = S_START;
                    tx_d      = 1'b0;
                    shift_d   = data_masked;
                    len_d     = len_eff;
                    par_en_d  = (bus_if.i_cfg_parity == 2'b01) || (bus_if.i_cfg_parity == 2'b10);
                    par_bit_d = (^data_masked) ^ (bus_if.i_cfg_parity == 2'b10);
                    stop2_d   = bus_if.i_cfg_stop2;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == len_q - NB_LEN'(1)) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP1;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + NB_LEN'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP1;
                    tx_d    = 1'b1;
                end
            end
            S_STOP1: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                tick_d = '0;
                tx_d   = 1'b0;
                if (!i_break) begin
                    state_d = S_BREAK_MARK;
                    tx_d    = 1'b1;
                end
            end
            S_BREAK_MARK: begin
                tx_d = 1'b1;
                if (bit_end)
                    state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            len_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            len_q     <= len_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign o_tx           = tx_q;
    assign o_tx_done_tick = done_q;
    assign o_busy         = (state_q != S_IDLE);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: directed frames with hand-computed line images, checked by a serial-line monitor.
// Expected entry layout: {cycles_per_bit[9:0], nbits[3:0], line_bits[11:0]}, line_bits[0] is the start bit.
module tb_uart_tx_cfg;

  localparam int W = 26;

  logic clk = 1'b0;
  logic rst;
  logic s_tick;
  logic o_busy, o_done, o_tx;
  logic [2:0] dbg_state;
`ifdef UART_TX_BREAK_EN
  logic brk;
`endif

  uart_tx_cfg_if #(.DBIT_MAX(8), .NB_LEN(4)) bus ();

  uart_tx_cfg #(.DBIT_MAX(8), .SB_TICK(16), .NB_LEN(4)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_s_tick       (s_tick),
`ifdef UART_TX_BREAK_EN
    .i_break        (brk),
`endif
    .bus_if         (bus.slave),
    .o_busy         (o_busy),
    .o_tx_done_tick (o_done),
    .o_tx           (o_tx),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  int tick_div = 1;
  int tick_cnt = 0;
  initial begin
    s_tick = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tick_cnt = (tick_cnt + 1) % tick_div;
      s_tick = (tick_cnt == 0);
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_exp = 0;
  int done_seen = 0;
  int frame_no = 0;
  bit mon_en = 1'b1;
  bit prev_busy = 1'b0;

  function automatic logic [W-1:0] mk(input logic [11:0] bits, input int nbits, input int cpb);
    logic [W-1:0] e;
    e = {10'(cpb), 4'(nbits), bits};
    return e;
  endfunction

  task automatic check_frame(input logic [W-1:0] e);
    logic [11:0] bits;
    int nb, cpb;
    bit bad, ab;
    bits = e[11:0];
    nb   = int'(e[15:12]);
    cpb  = int'(e[25:16]);
    ab   = 1'b0;
    for (int b = 0; b < nb && !ab; b++) begin
      bad = 1'b0;
      for (int c = 0; c < cpb && !ab; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (o_tx !== bits[b]) bad = 1'b1;
        if (rst) ab = 1'b1;
      end
      n_vec++;
      if (bad) begin
        n_err++;
        $display("FAIL frame%0d_bit%0d: line got %b at least once, want %b", frame_no, b, ~bits[b], bits[b]);
      end
    end
    @(negedge clk);
    n_vec++;
    if (ab) begin
      if (!(o_tx === 1'b1 && o_busy === 1'b0 && bus.o_ready === 1'b1 && o_done === 1'b0)) begin
        n_err++;
        $display("FAIL frame%0d_reset_abort: tx/busy/ready/done got %b%b%b%b want 1010",
                 frame_no, o_tx, o_busy, bus.o_ready, o_done);
      end
    end else begin
      if (!(o_done === 1'b1 && bus.o_ready === 1'b1 && o_busy === 1'b0)) begin
        n_err++;
        $display("FAIL frame%0d_done: done/ready/busy got %b%b%b want 110",
                 frame_no, o_done, bus.o_ready, o_busy);
      end
    end
    frame_no++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && o_busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_frame: frame started got busy=1 want no frame");
          prev_busy = o_busy;
        end else begin
          check_frame(exp_q.pop_front());
          prev_busy = o_busy;
        end
      end else begin
        prev_busy = o_busy;
      end
    end
  end

  always @(negedge clk) if (o_done === 1'b1) done_seen++;

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] d, input logic [3:0] len, input logic [1:0] par,
                      input logic st2, input logic [W-1:0] e, input bit hold, input bit completes);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #2;
      t++;
    end while (!(bus.o_ready && s_tick) && t < 3000);
    if (t >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: ready got 0 want 1");
    end
    bus.i_data = d;
    bus.i_cfg_len = len;
    bus.i_cfg_parity = par;
    bus.i_cfg_stop2 = st2;
    bus.i_valid = 1'b1;
    exp_q.push_back(e);
    if (completes) done_exp++;
    @(posedge clk);
    #2;
    if (!hold) begin
      bus.i_valid = 1'b0;
      bus.i_data = 8'($urandom_range(0, 255));
      bus.i_cfg_len = 4'($urandom_range(0, 15));
      bus.i_cfg_parity = 2'($urandom_range(0, 3));
      bus.i_cfg_stop2 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_done(input int limit);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #2;
      t++;
    end while (!o_done && t < limit);
    if (t >= limit) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_done_timeout: done got 0 want 1");
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    bus.i_cfg_len = 4'd8;
    bus.i_cfg_parity = 2'b00;
    bus.i_cfg_stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    n_vec++;
    if (!(o_tx === 1'b1 && bus.o_ready === 1'b1 && o_busy === 1'b0 && o_done === 1'b0)) begin
      n_err++;
      $display("FAIL reset_state: tx/ready/busy/done got %b%b%b%b want 1100", o_tx, bus.o_ready, o_busy, o_done);
    end

    // 8N1 0xA5
    send(8'hA5, 4'd8, 2'b00, 1'b0, mk({2'b00, 1'b1, 8'hA5, 1'b0}, 10, 16), 1'b0, 1'b1);
    // 7E1 0xC1: bit7 dropped, low seven bits 0x41 have two ones -> parity 0
    send(8'hC1, 4'd7, 2'b01, 1'b0, mk({2'b00, 1'b1, 1'b0, 7'h41, 1'b0}, 10, 16), 1'b0, 1'b1);

    // 8O2 0x00 with a tick every 4 cycles: parity 1, 12 bits of 64 cycles
    wait_done(4000);
    tick_div = 4;
    send(8'h00, 4'd8, 2'b10, 1'b1, mk({2'b11, 1'b1, 8'h00, 1'b0}, 12, 64), 1'b0, 1'b1);
    wait_done(4000);
    tick_div = 1;

    // Back-to-back with valid held; cfg disturbed mid-frame then restored before the done cycle
    send(8'h55, 4'd8, 2'b00, 1'b0, mk({2'b00, 1'b1, 8'h55, 1'b0}, 10, 16), 1'b1, 1'b1);
    bus.i_data = 8'h0F;
    bus.i_cfg_len = 4'd3;
    bus.i_cfg_parity = 2'b10;
    bus.i_cfg_stop2 = 1'b1;
    exp_q.push_back(mk({2'b00, 1'b1, 8'h0F, 1'b0}, 10, 16));
    done_exp++;
    repeat (50) @(posedge clk);
    #2;
    bus.i_cfg_len = 4'd8;
    bus.i_cfg_parity = 2'b00;
    bus.i_cfg_stop2 = 1'b0;
    wait_done(400);
    @(posedge clk);
    #2;
    bus.i_valid = 1'b0;

    // Reset during data bit 3 of an all-zero frame
    send(8'h00, 4'd8, 2'b00, 1'b0, mk({2'b00, 1'b1, 8'h00, 1'b0}, 10, 16), 1'b0, 1'b0);
    repeat (66) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;

    // len=0 clamps to 8, even parity of 0x3C (four ones) -> 0
    send(8'h3C, 4'd0, 2'b01, 1'b0, mk({2'b00, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 16), 1'b0, 1'b1);
    // len=12 clamps to 8, no parity (mode 11), two stop bits
    send(8'h81, 4'd12, 2'b11, 1'b1, mk({1'b0, 2'b11, 8'h81, 1'b0}, 11, 16), 1'b0, 1'b1);
    // len=1 odd parity of 0xFE -> only bit0 (0) sent, parity 1
    send(8'hFE, 4'd1, 2'b10, 1'b0, mk({8'h00, 1'b1, 1'b1, 1'b0, 1'b0}, 4, 16), 1'b0, 1'b1);

`ifdef UART_TX_BREAK_EN
    begin
      bit bad_lo, bad_mk;
      wait_done(1000);
      mon_en = 1'b0;
      @(posedge clk);
      #2;
      brk = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_data = 8'hFF;
      bad_lo = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #2;
        if (!(o_tx === 1'b0 && bus.o_ready === 1'b0 && o_busy === 1'b1)) bad_lo = 1'b1;
      end
      brk = 1'b0;
      bus.i_valid = 1'b0;
      n_vec++;
      if (bad_lo) begin
        n_err++;
        $display("FAIL break_low: line/ready got non-break value want tx=0 ready=0 for 40 cycles");
      end
      bad_mk = 1'b0;
      for (int c = 0; c < 16; c++) begin
        @(posedge clk);
        #2;
        if (!(o_tx === 1'b1 && bus.o_ready === 1'b0)) bad_mk = 1'b1;
      end
      n_vec++;
      if (bad_mk) begin
        n_err++;
        $display("FAIL break_mark: line/ready got wrong value want tx=1 ready=0 for 16 cycles");
      end
      @(posedge clk);
      #2;
      n_vec++;
      if (bus.o_ready !== 1'b1) begin
        n_err++;
        $display("FAIL break_exit: ready got %b want 1", bus.o_ready);
      end
      mon_en = 1'b1;
    end
`endif

    t = 0;
    while ((exp_q.size() != 0 || o_busy) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (5) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0 || o_busy) begin
      n_err++;
      $display("FAIL drain_timeout: queue %0d busy %b want 0 0", exp_q.size(), o_busy);
    end
    n_vec++;
    if (done_seen != done_exp) begin
      n_err++;
      $display("FAIL done_count: got %0d pulses want %0d", done_seen, done_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
